// File: rtl/dff_sr.sv
// SR flip-flop built from a D register and S/R-to-D next-state logic.
// The S=R=1 case resolves according to SR11_MODE so the output is always defined.
module dff_sr #(
    parameter int WIDTH     = 1,
    parameter int SR11_MODE = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] S,
    input  logic [WIDTH-1:0] R,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] QB
);

    // Out-of-range modes fall back to set-dominant behaviour.
    localparam int MODE = (SR11_MODE < 0 || SR11_MODE > 3) ? 0 : SR11_MODE;

    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] d_next;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            always_comb begin
                d_next[gi] = q_reg[gi];
                unique case ({S[gi], R[gi]})
                    2'b00: d_next[gi] = q_reg[gi];
                    2'b10: d_next[gi] = 1'b1;
                    2'b01: d_next[gi] = 1'b0;
                    2'b11: begin
                        case (MODE)
                            1:       d_next[gi] = 1'b0;
                            2:       d_next[gi] = q_reg[gi];
                            3:       d_next[gi] = ~q_reg[gi];
                            default: d_next[gi] = 1'b1;
                        endcase
                    end
                    default: d_next[gi] = q_reg[gi];
                endcase
            end
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (!reset) begin
            q_reg <= '0;
        end else begin
            q_reg <= d_next;
        end
    end

    // Both outputs come straight off the one register, so QB can never equal Q.
    assign Q  = q_reg;
    assign QB = ~q_reg;

endmodule

// File: tb/tb_dff_sr.sv
// Directed testbench for dff_sr: reset, set/hold/clear, S=R=1 modes,
// mid-cycle reset, between-edge glitches and a 4-bit instance.
module tb_dff_sr;

    logic clock;
    logic reset;
    logic s0, r0, s1, r1, s2, r2, s3, r3, s7, r7;
    logic q0, qb0, q1, qb1, q2, qb2, q3, qb3, q7, qb7;
    logic [3:0] s4w, r4w, q4w, qb4w;

    int checks   = 0;
    int failures = 0;

    dff_sr #(.WIDTH(1), .SR11_MODE(0)) u_m0 (.clock(clock), .reset(reset), .S(s0), .R(r0), .Q(q0), .QB(qb0));
    dff_sr #(.WIDTH(1), .SR11_MODE(1)) u_m1 (.clock(clock), .reset(reset), .S(s1), .R(r1), .Q(q1), .QB(qb1));
    dff_sr #(.WIDTH(1), .SR11_MODE(2)) u_m2 (.clock(clock), .reset(reset), .S(s2), .R(r2), .Q(q2), .QB(qb2));
    dff_sr #(.WIDTH(1), .SR11_MODE(3)) u_m3 (.clock(clock), .reset(reset), .S(s3), .R(r3), .Q(q3), .QB(qb3));
    dff_sr #(.WIDTH(1), .SR11_MODE(7)) u_m7 (.clock(clock), .reset(reset), .S(s7), .R(r7), .Q(q7), .QB(qb7));
    dff_sr #(.WIDTH(4), .SR11_MODE(0)) u_w4 (.clock(clock), .reset(reset), .S(s4w), .R(r4w), .Q(q4w), .QB(qb4w));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance past the next rising edge and settle for sampling.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        s0 = 1'b1; r0 = 1'b0; s1 = 1'b1; r1 = 1'b0; s2 = 1'b1; r2 = 1'b0;
        s3 = 1'b1; r3 = 1'b0; s7 = 1'b1; r7 = 1'b0; s4w = 4'hF; r4w = 4'h0;
        step();
        step();
        checks++; if (q0 !== 1'b0)  begin failures++; $display("FAIL reset_q0 got=%b exp=0", q0); end
        checks++; if (qb0 !== 1'b1) begin failures++; $display("FAIL reset_qb0 got=%b exp=1", qb0); end
        checks++; if (q3 !== 1'b0)  begin failures++; $display("FAIL reset_q3 got=%b exp=0", q3); end
        checks++; if (q4w !== 4'h0) begin failures++; $display("FAIL reset_q4w got=%b exp=0000", q4w); end
        checks++; if (qb4w !== 4'hF) begin failures++; $display("FAIL reset_qb4w got=%b exp=1111", qb4w); end
        $display("test_reset: q0=%b qb0=%b q4w=%b", q0, qb0, q4w);
    endtask

    task automatic test_set_hold();
        reset = 1'b1;
        s0 = 1'b1; r0 = 1'b0;
        step();
        checks++; if (q0 !== 1'b1)  begin failures++; $display("FAIL set_q got=%b exp=1", q0); end
        checks++; if (qb0 !== 1'b0) begin failures++; $display("FAIL set_qb got=%b exp=0", qb0); end
        s0 = 1'b0; r0 = 1'b0;
        step();
        checks++; if (q0 !== 1'b1) begin failures++; $display("FAIL hold1_q got=%b exp=1", q0); end
        step();
        checks++; if (q0 !== 1'b1) begin failures++; $display("FAIL hold2_q got=%b exp=1", q0); end
        $display("test_set_hold: q0=%b qb0=%b", q0, qb0);
    endtask

    task automatic test_clear_latency();
        s0 = 1'b0; r0 = 1'b1;
        step();
        checks++; if (q0 !== 1'b0)  begin failures++; $display("FAIL clear_q got=%b exp=0", q0); end
        checks++; if (qb0 !== 1'b1) begin failures++; $display("FAIL clear_qb got=%b exp=1", qb0); end
        s0 = 1'b1; r0 = 1'b0;
        #2;
        checks++; if (q0 !== 1'b0) begin failures++; $display("FAIL early_set_q got=%b exp=0", q0); end
        step();
        checks++; if (q0 !== 1'b1) begin failures++; $display("FAIL late_set_q got=%b exp=1", q0); end
        $display("test_clear_latency: q0=%b", q0);
    endtask

    task automatic test_sr11_modes();
        // Prepare: mode 0 and illegal mode at Q=0, modes 1/2/3 at Q=1.
        s0 = 1'b0; r0 = 1'b1; s7 = 1'b0; r7 = 1'b1;
        s1 = 1'b1; r1 = 1'b0; s2 = 1'b1; r2 = 1'b0; s3 = 1'b1; r3 = 1'b0;
        step();
        s0 = 1'b1; r0 = 1'b1; s1 = 1'b1; r1 = 1'b1; s2 = 1'b1; r2 = 1'b1;
        s3 = 1'b1; r3 = 1'b1; s7 = 1'b1; r7 = 1'b1;
        step();
        checks++; if (q0 !== 1'b1)  begin failures++; $display("FAIL sr11_m0_q got=%b exp=1", q0); end
        checks++; if (qb0 !== 1'b0) begin failures++; $display("FAIL sr11_m0_qb got=%b exp=0", qb0); end
        checks++; if (q1 !== 1'b0)  begin failures++; $display("FAIL sr11_m1_q got=%b exp=0", q1); end
        checks++; if (qb1 !== 1'b1) begin failures++; $display("FAIL sr11_m1_qb got=%b exp=1", qb1); end
        checks++; if (q2 !== 1'b1)  begin failures++; $display("FAIL sr11_m2_q got=%b exp=1", q2); end
        checks++; if (qb2 !== 1'b0) begin failures++; $display("FAIL sr11_m2_qb got=%b exp=0", qb2); end
        checks++; if (q3 !== 1'b0)  begin failures++; $display("FAIL sr11_m3_q got=%b exp=0", q3); end
        checks++; if (qb3 !== 1'b1) begin failures++; $display("FAIL sr11_m3_qb got=%b exp=1", qb3); end
        checks++; if (q7 !== 1'b1)  begin failures++; $display("FAIL sr11_m7_q got=%b exp=1", q7); end
        step();
        checks++; if (q3 !== 1'b1) begin failures++; $display("FAIL sr11_m3_toggle2 got=%b exp=1", q3); end
        checks++; if (q2 !== 1'b1) begin failures++; $display("FAIL sr11_m2_hold2 got=%b exp=1", q2); end
        checks++; if (q1 !== 1'b0) begin failures++; $display("FAIL sr11_m1_again got=%b exp=0", q1); end
        $display("test_sr11_modes: q0=%b q1=%b q2=%b q3=%b q7=%b", q0, q1, q2, q3, q7);
        s1 = 1'b0; r1 = 1'b0; s2 = 1'b0; r2 = 1'b0; s3 = 1'b0; r3 = 1'b0; s7 = 1'b0; r7 = 1'b0;
    endtask

    task automatic test_reset_mid();
        s0 = 1'b1; r0 = 1'b0;
        step();
        checks++; if (q0 !== 1'b1) begin failures++; $display("FAIL mid_pre_q got=%b exp=1", q0); end
        #2;
        reset = 1'b0;
        #2;
        checks++; if (q0 !== 1'b1) begin failures++; $display("FAIL mid_between_q got=%b exp=1", q0); end
        step();
        checks++; if (q0 !== 1'b0)  begin failures++; $display("FAIL mid_after_q got=%b exp=0", q0); end
        checks++; if (qb0 !== 1'b1) begin failures++; $display("FAIL mid_after_qb got=%b exp=1", qb0); end
        reset = 1'b1;
        $display("test_reset_mid: q0=%b qb0=%b", q0, qb0);
    endtask

    task automatic test_glitch();
        s0 = 1'b0; r0 = 1'b0;
        step();
        #1;
        s0 = 1'b1;
        #4;
        s0 = 1'b0;
        step();
        checks++; if (q0 !== 1'b0) begin failures++; $display("FAIL glitch_q got=%b exp=0", q0); end
        $display("test_glitch: q0=%b", q0);
    endtask

    task automatic test_width4();
        s4w = 4'b0010; r4w = 4'b1101;
        step();
        checks++; if (q4w !== 4'b0010) begin failures++; $display("FAIL w4_init got=%b exp=0010", q4w); end
        s4w = 4'b0101; r4w = 4'b0010;
        step();
        checks++; if (q4w !== 4'b0101)  begin failures++; $display("FAIL w4_mix_q got=%b exp=0101", q4w); end
        checks++; if (qb4w !== 4'b1010) begin failures++; $display("FAIL w4_mix_qb got=%b exp=1010", qb4w); end
        s4w = 4'b0000; r4w = 4'b0100;
        step();
        checks++; if (q4w !== 4'b0001) begin failures++; $display("FAIL w4_clear_q got=%b exp=0001", q4w); end
        s4w = 4'b1100; r4w = 4'b1100;
        step();
        checks++; if (q4w !== 4'b1101) begin failures++; $display("FAIL w4_sr11_q got=%b exp=1101", q4w); end
        $display("test_width4: q4w=%b qb4w=%b", q4w, qb4w);
    endtask

    initial begin
        reset = 1'b0;
        s0 = 1'b0; r0 = 1'b0; s1 = 1'b0; r1 = 1'b0; s2 = 1'b0; r2 = 1'b0;
        s3 = 1'b0; r3 = 1'b0; s7 = 1'b0; r7 = 1'b0; s4w = 4'h0; r4w = 4'h0;
        test_reset();
        test_set_hold();
        test_clear_latency();
        test_sr11_modes();
        test_reset_mid();
        test_glitch();
        test_width4();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
